// File: rtl/kt2_operand_align.sv
// Operand alignment buffer ahead of kt2: four per-channel FIFOs that release
// one operand from every channel together once all four are non-empty.

module kt2_align_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [63:0] din,
    input  logic        pop,
    output logic [63:0] dout,
    output logic        nempty,
    output logic        ovf
);
    logic [63:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          full, wr_en;

    assign full   = (cnt == (AW+1)'(DEPTH));
    assign nempty = (cnt != '0);
    // A full FIFO still accepts a word when the same cycle pops it.
    assign wr_en  = push && (!full || pop);
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            if (push && !wr_en) ovf <= 1'b1;
        end
    end
endmodule

module kt2_operand_align #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      psi_i_in,
    input  logic             psi_i_in_vld,
    input  logic [63:0]      psi_pow4_in,
    input  logic             psi_pow4_in_vld,
    input  logic [63:0]      alpha_r_in,
    input  logic             alpha_r_in_vld,
    input  logic [63:0]      psi_r_in,
    input  logic             psi_r_in_vld,
    output logic [63:0]      psi_i,
    output logic [63:0]      psi_pow4,
    output logic             psipow4_vld,
    output logic [63:0]      alpha_r,
    output logic             alpha_r_vld,
    output logic [63:0]      psi_r,
    output logic             psi_r_vld,
    output logic [3:0]       ovf,
    output logic [CNT_W-1:0] tuple_cnt
);
    localparam int NUM_LANES = 4;
    localparam int STAGES    = 1;

    // Lane order matches ovf: {psi_r, alpha_r, psi_pow4, psi_i}.
    logic [NUM_LANES-1:0][63:0] din_lane, dout_lane, out_q;
    logic [NUM_LANES-1:0]       push_lane, nempty;
    logic [STAGES:0]            vld_pipe;
    logic                       rel_fire;

    assign push_lane = {psi_r_in_vld, alpha_r_in_vld, psi_pow4_in_vld, psi_i_in_vld};
    assign din_lane  = {psi_r_in, alpha_r_in, psi_pow4_in, psi_i_in};
    assign rel_fire  = &nempty;
    assign vld_pipe[0] = rel_fire;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        kt2_align_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .push   (push_lane[g]),
            .din    (din_lane[g]),
            .pop    (rel_fire),
            .dout   (dout_lane[g]),
            .nempty (nempty[g]),
            .ovf    (ovf[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[STAGES:1] <= '0;
            out_q              <= '0;
            tuple_cnt          <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (rel_fire) begin
                out_q     <= dout_lane;
                tuple_cnt <= tuple_cnt + CNT_W'(1);
            end
        end
    end

    assign psi_i       = out_q[0];
    assign psi_pow4    = out_q[1];
    assign alpha_r     = out_q[2];
    assign psi_r       = out_q[3];
    assign psipow4_vld = vld_pipe[STAGES];
    assign alpha_r_vld = vld_pipe[STAGES];
    assign psi_r_vld   = vld_pipe[STAGES];
endmodule

// File: doc/kt2_operand_align.md
# kt2_operand_align

Operand alignment buffer directly upstream of the kt2 stage. Four 64-bit IEEE-754 double operand streams arrive with independent valid strobes: psi_i, psi_pow4, alpha_r and psi_r. The block queues each stream in its own FIFO and releases one operand from every stream in the same cycle, with all four valids asserted together. This guarantees that the valid-AND joins inside kt2 always see matched operand sets.

## Interface
Parameters:
- DEPTH, 8, entries per channel FIFO; power of two, minimum 2
- CNT_W, 32, width of the released-tuple counter

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- psi_i_in  in  64  psi_i operand
- psi_i_in_vld  in  1  push strobe for psi_i_in
- psi_pow4_in  in  64  psi^4 operand
- psi_pow4_in_vld  in  1  push strobe for psi_pow4_in
- alpha_r_in  in  64  alpha_r operand
- alpha_r_in_vld  in  1  push strobe for alpha_r_in
- psi_r_in  in  64  psi_r operand
- psi_r_in_vld  in  1  push strobe for psi_r_in
- psi_i  out  64  aligned psi_i to kt2
- psi_pow4  out  64  aligned psi^4 to kt2
- psipow4_vld  out  1  valid for psi_i and psi_pow4
- alpha_r  out  64  aligned alpha_r to kt2
- alpha_r_vld  out  1  valid for alpha_r
- psi_r  out  64  aligned psi_r to kt2
- psi_r_vld  out  1  valid for psi_r
- ovf  out  4  sticky overflow flags, bit order {psi_r, alpha_r, psi_pow4, psi_i}
- tuple_cnt  out  CNT_W  number of tuples released since reset

## Operation
- Each channel has a FIFO of DEPTH x 64 bits with its own write pointer, read pointer and occupancy count (width log2(DEPTH)+1).
- Push: on any cycle the channel's *_in_vld is high, the FIFO writes the word when not full, or when full and a release pops that channel in the same cycle.
- Drop: a push into a full FIFO with no same-cycle pop discards the word and sets that channel's ovf bit. ovf bits clear only on rst.
- Release condition: all four FIFOs non-empty, evaluated on registered occupancy.
  - When it holds, every FIFO pops exactly one word in that cycle.
  - Next cycle: the four popped words appear on the outputs, and psipow4_vld, alpha_r_vld and psi_r_vld are all high.
- Release rate is at most one tuple per cycle. There is no downstream backpressure; kt2 accepts every cycle.
- Output valids are high only in the cycle after a release and low otherwise. Output data holds its last value while valids are low.
- tuple_cnt increments by 1 per release and wraps modulo 2^CNT_W.
- Push and pop on the same FIFO in the same cycle leave the occupancy unchanged. Pointers wrap modulo DEPTH.
- Order is strictly FIFO per channel: the k-th word pushed on each channel forms tuple k.

## Timing
- Reset values: all FIFOs empty, pointers 0, every *_vld output 0, all data outputs 64'h0, ovf 4'b0000, tuple_cnt 0.
- rst during operation flushes all FIFOs on that edge, including a tuple being released in that cycle. Valids are 0 in the following cycle, and pushes presented during rst are ignored.
- Latency: if the last missing operand of a tuple is pushed in cycle n, the outputs are valid in cycle n+2. Its occupancy becomes visible in n+1, when the release fires.
- Steady state: with all four channels pushing every cycle, the outputs are valid every cycle from n+2 onward at full throughput. Occupancy never exceeds 1.
- Empty boundary: a channel at occupancy 0 blocks release even if it is pushed in the same cycle. No bypass path.

## Test plan
- Aligned stream: push 4 tuples on all channels in cycles 0-3 with psi_i=k, psi_pow4=16k, alpha_r=2k, psi_r=3k (k=1..4 as doubles) -> valids high in cycles 2-5 carrying matching k; tuple_cnt=4.
- Skew: push psi_i and psi_pow4 in cycle 0, alpha_r in cycle 3, psi_r in cycle 7 -> single tuple, all valids high in cycle 9 only.
- Overflow: DEPTH=8; push 10 words on psi_i only, then one word on each other channel -> ovf=4'b0001; released psi_i is word 1; psi_i occupancy 7 after release.
- Full with simultaneous pop: fill psi_r to 8 with the other channels holding 1 word each. Push psi_r again in the release cycle -> word accepted, ovf[3]=0, psi_r occupancy stays 8.
- Mid-operation reset: 3 tuples partially queued; assert rst for 1 cycle -> next cycle all valids 0, ovf 0, tuple_cnt 0. A subsequent aligned push releases the fresh data with 2-cycle latency.
- Counter wrap: CNT_W=4; release 17 tuples -> tuple_cnt=1.
